// File: rtl/fm_wb_scheduler_pkg.sv
// rtl/fm_wb_scheduler_pkg.sv - shared types and constants for the feature-map write-back scheduler
package fm_wb_scheduler_pkg;

    typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DONE} wb_sched_state_e;

    localparam int WB_WORD_BYTES = 9;
    localparam int WB_WORD_BITS  = 72;

endpackage

// File: rtl/fm_wb_scheduler_rr_arbiter.sv
// rtl/fm_wb_scheduler_rr_arbiter.sv - round-robin arbiter, one grant per cycle, pointer moves past each winner
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] grant_o,
    output logic         gnt_valid_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, gnt_idx, idx;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        grant_o = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                gnt_idx      = idx;
            end
        end
        gnt_valid_o = found;
        ptr_d       = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fm_wb_scheduler.sv
// rtl/fm_wb_scheduler.sv - packs per-row write-back bytes into 72-bit words and schedules them into the fm buffer
module fm_wb_scheduler
    import fm_wb_scheduler_pkg::*;
#(
    parameter  int N_ROW = 4,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [N_ROW*AW-1:0]     base_addr_i,
    input  logic [N_ROW*8-1:0]      wb_data_i,
    input  logic [N_ROW-1:0]        wb_valid_i,
    input  logic [N_ROW-1:0]        wb_last_i,
    output logic [N_ROW-1:0]        wb_ready_o,
    output logic                    fm_wr_en_o,
    output logic [AW-1:0]           fm_wr_addr_o,
    output logic [WB_WORD_BITS-1:0] fm_din_o,
    output logic                    done_o,
    output logic                    ovf_o
);

    wb_sched_state_e         state_q;
    logic                    wr_en_q, done_q, ovf_q;
    logic [AW-1:0]           wr_addr_q;
    logic [WB_WORD_BITS-1:0] din_q;

    logic                    run, start_ok, gnt_valid;
    logic [N_ROW-1:0]        req_vec, done_vec, grant, fire, row_wrap;
    logic [WB_WORD_BITS-1:0] row_word [N_ROW];
    logic [AW-1:0]           row_addr [N_ROW];
    logic [WB_WORD_BITS-1:0] sel_word;
    logic [AW-1:0]           sel_addr;
    logic                    sel_wrap;

    assign run      = (state_q == WB_RUN);
    assign start_ok = (state_q == WB_IDLE) && start_i;
    assign fire     = grant & {N_ROW{run}};

    rr_arbiter #(.N(N_ROW)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_vec),
        .adv_i       (run),
        .grant_o     (grant),
        .gnt_valid_o (gnt_valid)
    );

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        logic [7:0]              lane_q [WB_WORD_BYTES];
        logic [3:0]              cnt_q;
        logic                    req_q, row_done_q, acc;
        logic [AW-1:0]           wcnt_q, base_q;
        logic [WB_WORD_BITS-1:0] word_c;

        assign wb_ready_o[r] = run && (cnt_q < 4'(WB_WORD_BYTES)) && !req_q && !row_done_q;
        assign acc           = wb_valid_i[r] && wb_ready_o[r];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q      <= '0;
                req_q      <= 1'b0;
                row_done_q <= 1'b0;
                wcnt_q     <= '0;
                base_q     <= '0;
                for (int k = 0; k < WB_WORD_BYTES; k++) lane_q[k] <= '0;
            end else if (start_ok) begin
                cnt_q      <= '0;
                req_q      <= 1'b0;
                row_done_q <= 1'b0;
                wcnt_q     <= '0;
                base_q     <= base_addr_i[r*AW +: AW];
            end else if (fire[r]) begin
                cnt_q  <= '0;
                req_q  <= 1'b0;
                wcnt_q <= wcnt_q + AW'(1);
            end else if (acc) begin
                lane_q[cnt_q] <= wb_data_i[r*8 +: 8];
                cnt_q         <= cnt_q + 4'd1;
                if (cnt_q == 4'(WB_WORD_BYTES-1) || wb_last_i[r]) req_q <= 1'b1;
                if (wb_last_i[r]) row_done_q <= 1'b1;
            end
        end

        // Lanes beyond the fill count still hold bytes of the previous word; mask them.
        always_comb begin
            word_c = '0;
            for (int k = 0; k < WB_WORD_BYTES; k++) begin
                if (4'(k) < cnt_q) word_c[8*k +: 8] = lane_q[k];
            end
        end

        assign row_word[r] = word_c;
        assign row_addr[r] = base_q + wcnt_q;
        // Flag when either the word counter or the running address is about to roll over.
        assign row_wrap[r] = (&wcnt_q) || (&row_addr[r]);
        assign req_vec[r]  = req_q;
        assign done_vec[r] = row_done_q;
    end

    always_comb begin
        sel_word = '0;
        sel_addr = '0;
        sel_wrap = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            if (grant[r]) begin
                sel_word = row_word[r];
                sel_addr = row_addr[r];
                sel_wrap = row_wrap[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            din_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (start_i) begin
                        state_q <= WB_RUN;
                        ovf_q   <= 1'b0;
                    end
                end
                WB_RUN: begin
                    if (gnt_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= sel_addr;
                        din_q     <= sel_word;
                        if (sel_wrap) ovf_q <= 1'b1;
                    end
                    if ((&done_vec) && !(|req_vec)) begin
                        state_q <= WB_DONE;
                        done_q  <= 1'b1;
                    end
                end
                WB_DONE: state_q <= WB_IDLE;
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    assign fm_wr_en_o   = wr_en_q;
    assign fm_wr_addr_o = wr_addr_q;
    assign fm_din_o     = din_q;
    assign done_o       = done_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_fm_wb_scheduler.sv
// tb/tb_fm_wb_scheduler.sv - directed self-checking bench for fm_wb_scheduler
module tb_fm_wb_scheduler;

    localparam int N_ROW = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic [N_ROW*AW-1:0]   base_addr_i = '0;
    logic [N_ROW*8-1:0]    wb_data_i = '0;
    logic [N_ROW-1:0]      wb_valid_i = '0;
    logic [N_ROW-1:0]      wb_last_i = '0;
    logic [N_ROW-1:0]      wb_ready_o;
    logic                  fm_wr_en_o;
    logic [AW-1:0]         fm_wr_addr_o;
    logic [71:0]           fm_din_o;
    logic                  done_o;
    logic                  ovf_o;

    fm_wb_scheduler #(.N_ROW(N_ROW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .wb_data_i    (wb_data_i),
        .wb_valid_i   (wb_valid_i),
        .wb_last_i    (wb_last_i),
        .wb_ready_o   (wb_ready_o),
        .fm_wr_en_o   (fm_wr_en_o),
        .fm_wr_addr_o (fm_wr_addr_o),
        .fm_din_o     (fm_din_o),
        .done_o       (done_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-row byte script: [9]=idle slot, [8]=last, [7:0]=data
    logic [9:0] bmem [N_ROW][64];
    int head [N_ROW];
    int tail [N_ROW];
    logic [N_ROW-1:0] vld_prev = '0, rdy_prev = '0, bub_prev = '0;

    task automatic flush();
        for (int r = 0; r < N_ROW; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        bmem[r][tail[r]] = {1'b0, last, d};
        tail[r]++;
    endtask

    task automatic idle_slots(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            bmem[r][tail[r]] = 10'h200;
            tail[r]++;
        end
    endtask

    always @(negedge clk) begin
        for (int r = 0; r < N_ROW; r++) begin
            if (!rst_n) begin
                wb_valid_i[r] = 1'b0;
                vld_prev[r]   = 1'b0;
                rdy_prev[r]   = 1'b0;
                bub_prev[r]   = 1'b0;
            end else begin
                if (rdy_prev[r] && (vld_prev[r] || bub_prev[r])) head[r]++;
                wb_valid_i[r]        = 1'b0;
                wb_last_i[r]         = 1'b0;
                wb_data_i[r*8 +: 8]  = 8'h00;
                bub_prev[r]          = 1'b0;
                if (head[r] != tail[r]) begin
                    if (bmem[r][head[r]][9]) begin
                        bub_prev[r] = 1'b1;
                    end else begin
                        wb_valid_i[r]       = 1'b1;
                        wb_last_i[r]        = bmem[r][head[r]][8];
                        wb_data_i[r*8 +: 8] = bmem[r][head[r]][7:0];
                    end
                end
                vld_prev[r] = wb_valid_i[r];
                rdy_prev[r] = wb_ready_o[r];
            end
        end
    end

    logic [AW-1:0] wa [64];
    logic [71:0]   wd [64];
    int            wc [64];
    int nwr = 0, ndone = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fm_wr_en_o && nwr < 64) begin
                wa[nwr] = fm_wr_addr_o;
                wd[nwr] = fm_din_o;
                wc[nwr] = cyc;
                nwr++;
            end
            if (done_o) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    int t0, nw0, nd0;

    task automatic start_run(input logic [N_ROW*AW-1:0] bases);
        @(negedge clk);
        base_addr_i = bases;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        t0  = cyc;
        nw0 = nwr;
        nd0 = ndone;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (ndone == nd0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 72'(ndone - nd0), 72'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush();
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [AW-1:0] e_addr [7];
    logic [71:0]   e_data [7];
    int n_hold;

    initial begin
        flush();
        repeat (2) @(negedge clk);
        check("rst_wr_en", 72'(fm_wr_en_o), 72'd0);
        check("rst_ready", 72'(wb_ready_o), 72'd0);
        check("rst_done", 72'(done_o), 72'd0);
        check("rst_ovf", 72'(ovf_o), 72'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 72'(wb_ready_o), 72'd0);

        // Full word on row 0, partial flush on row 1, single bytes on rows 2/3
        for (int i = 0; i < 9; i++) push(0, 8'(i + 1), i == 8);
        push(1, 8'hAA, 1'b0); push(1, 8'hBB, 1'b0); push(1, 8'hCC, 1'b0); push(1, 8'hDD, 1'b1);
        push(2, 8'hE2, 1'b1);
        push(3, 8'hE3, 1'b1);
        start_run({6'h33, 6'h32, 6'h20, 6'h10});
        check("t1_ready_t1", 72'(wb_ready_o), 72'hF);
        wait_done("t1_done");
        check("t1_nwr", 72'(nwr - nw0), 72'd4);
        check("t1_w0_addr", 72'(wa[nw0]), 72'h32);
        check("t1_w0_data", wd[nw0], 72'hE2);
        check("t1_w1_addr", 72'(wa[nw0+1]), 72'h33);
        check("t1_w2_addr", 72'(wa[nw0+2]), 72'h20);
        check("t1_w2_data", wd[nw0+2], 72'h00000000_00DDCCBBAA);
        check("t1_w2_lat", 72'(wc[nw0+2] - t0), 72'd5);
        check("t1_w3_addr", 72'(wa[nw0+3]), 72'h10);
        check("t1_w3_data", wd[nw0+3], 72'h090807060504030201);
        check("t1_w3_lat", 72'(wc[nw0+3] - t0), 72'd10);
        check("t1_done_lat", 72'(done_cyc - wc[nw0+3]), 72'd1);
        check("t1_ovf", 72'(ovf_o), 72'd0);

        // Asynchronous reset with a 5-byte partial word in row 0
        for (int i = 0; i < 5; i++) push(0, 8'(8'hC1 + i), 1'b0);
        start_run({6'h04, 6'h03, 6'h02, 6'h01});
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_wr_en", 72'(fm_wr_en_o), 72'd0);
        check("mr_addr", 72'(fm_wr_addr_o), 72'd0);
        check("mr_din", fm_din_o, 72'd0);
        check("mr_ready", 72'(wb_ready_o), 72'd0);
        check("mr_done", 72'(done_o), 72'd0);
        check("mr_ovf", 72'(ovf_o), 72'd0);
        flush();
        repeat (3) @(negedge clk);
        check("mr_no_write", 72'(nwr - nw0), 72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: rows 0..2 finish words together, row 3 joins later against row 0
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 9; i++) push(r, 8'(r*16 + i + 1), 1'b0);
            push(r, 8'(8'hF0 + r), 1'b1);
        end
        idle_slots(3, 11);
        push(3, 8'h77, 1'b1);
        start_run({6'h18, 6'h10, 6'h08, 6'h00});
        wait_done("t3_done");
        e_addr = '{6'h00, 6'h08, 6'h10, 6'h18, 6'h01, 6'h09, 6'h11};
        e_data = '{72'h090807060504030201, 72'h191817161514131211, 72'h292827262524232221,
                   72'h77, 72'hF0, 72'hF1, 72'hF2};
        check("t3_nwr", 72'(nwr - nw0), 72'd7);
        for (int i = 0; i < 7; i++) begin
            check("t3_addr", 72'(wa[nw0+i]), 72'(e_addr[i]));
            check("t3_data", wd[nw0+i], e_data[i]);
        end
        check("t3_w0_lat", 72'(wc[nw0] - t0), 72'd10);
        check("t3_back2back", 72'(wc[nw0+2] - wc[nw0]), 72'd2);

        // Backpressure: row 0 completes a word while rows 1..3 are ahead of it
        do_reset();
        idle_slots(0, 1);
        for (int i = 0; i < 18; i++) push(0, 8'(8'h40 + i), i == 17);
        for (int r = 1; r < N_ROW; r++)
            for (int i = 0; i < 9; i++) push(r, 8'(r*16 + i), i == 8);
        start_run({6'h03, 6'h02, 6'h01, 6'h3A});
        repeat (10) @(negedge clk);
        check("t4_stall_c10", 72'(wb_ready_o[0]), 72'd0);
        @(negedge clk);
        check("t4_stall_c11", 72'(wb_ready_o[0]), 72'd0);
        repeat (2) @(negedge clk);
        check("t4_ready_c13", 72'(wb_ready_o[0]), 72'd1);
        wait_done("t4_done");
        check("t4_nwr", 72'(nwr - nw0), 72'd5);
        check("t4_w3_addr", 72'(wa[nw0+3]), 72'h3A);
        check("t4_w3_data", wd[nw0+3], 72'h484746454443424140);
        check("t4_w4_addr", 72'(wa[nw0+4]), 72'h3B);
        check("t4_w4_data", wd[nw0+4], 72'h51504F4E4D4C4B4A49);

        // Address wrap and sticky overflow
        do_reset();
        for (int i = 0; i < 18; i++) push(0, 8'(8'h60 + i), i == 17);
        push(1, 8'h11, 1'b1); push(2, 8'h22, 1'b1); push(3, 8'h33, 1'b1);
        start_run({6'h22, 6'h21, 6'h20, 6'h3F});
        wait_done("t5_done");
        check("t5_nwr", 72'(nwr - nw0), 72'd5);
        check("t5_w3_addr", 72'(wa[nw0+3]), 72'h3F);
        check("t5_w3_data", wd[nw0+3], 72'h686766656463626160);
        check("t5_w4_addr", 72'(wa[nw0+4]), 72'h00);
        check("t5_w4_data", wd[nw0+4], 72'h71706F6E6D6C6B6A69);
        repeat (3) @(negedge clk);
        check("t5_ovf_sticky", 72'(ovf_o), 72'd1);
        for (int r = 0; r < N_ROW; r++) push(r, 8'(8'h80 + r), 1'b1);
        start_run({6'h0D, 6'h0C, 6'h0B, 6'h0A});
        check("t5_ovf_cleared", 72'(ovf_o), 72'd0);
        wait_done("t5b_done");
        check("t5b_nwr", 72'(nwr - nw0), 72'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
